// File: rtl/snn_encoder_pkg.sv
// Shared definitions for the rank-order spike encoder: default frame geometry
// (also used by sorter2) and the scheduler state encoding.
package snn_encoder_pkg;

  localparam int DEFAULT_IMAGE_SIZE      = 5;
  localparam int DEFAULT_PIXEL_MAX_VALUE = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SORT   = 3'd2,
    S_EMIT   = 3'd3,
    S_GAP    = 3'd4,
    S_FINISH = 3'd5
  } sched_state_t;

endpackage

// File: rtl/spike_gap_timer.sv
// Loadable down-counter that paces spikes; counts down to zero after a load
// and raises zero while idle.
module spike_gap_timer #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] gap_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge CLK) begin
    if (RST)
      gap_cnt <= '0;
    else if (load)
      gap_cnt <= load_value;
    else if (gap_cnt != '0)
      gap_cnt <= gap_cnt - W'(1);
  end

  assign zero = (gap_cnt == '0);

endmodule

// File: rtl/rank_spike_scheduler.sv
// Drives one sorter2 pass per frame and streams the sorted pixel indexes as
// address-event spikes. Optional macro SPIKE_TIMESTAMP_EN adds spike_time.
module rank_spike_scheduler
  import snn_encoder_pkg::*;
#(
  parameter int IMAGE_SIZE      = DEFAULT_IMAGE_SIZE,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = DEFAULT_PIXEL_MAX_VALUE,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
  parameter int SPIKE_GAP       = 0,
  parameter int TS_BITS         = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   img_valid,
  output logic                   img_ready,
  input  logic [PIXEL_BITS:0]    image [0:IMAGE_SIZE-1],
  input  logic                   abort,
  output logic [PIXEL_BITS:0]    sort_image [0:IMAGE_SIZE-1],
  output logic                   sort_start,
  input  logic                   sort_done,
  input  logic [PIXEL_BITS:0]    sorted_indexes [0:IMAGE_SIZE-1],
  output logic                   spike_valid,
  input  logic                   spike_ready,
  output logic [IMAGE_SIZE_BITS:0] spike_addr,
  output logic                   spike_last,
  output logic                   busy,
  output logic                   frame_done
`ifdef SPIKE_TIMESTAMP_EN
  ,
  output logic [TS_BITS-1:0]     spike_time
`endif
);

  localparam int IDX_W = IMAGE_SIZE_BITS + 1;
  localparam int SEL_W = (IMAGE_SIZE_BITS > 0) ? IMAGE_SIZE_BITS : 1;
  localparam int GAP_W = ($clog2(SPIKE_GAP + 1) > 1) ? $clog2(SPIKE_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((SPIKE_GAP > 0) ? SPIKE_GAP - 1 : 0);

  sched_state_t         state_q, state_d;
  logic [IDX_W-1:0]     rank_q;
  logic [IDX_W-1:0]     sidx_q  [0:IMAGE_SIZE-1];
  logic [PIXEL_BITS:0]  image_q [0:IMAGE_SIZE-1];
  logic                 last_rank;
  logic                 gap_load;
  logic                 gap_zero;
  logic [IMAGE_SIZE-1:0] sidx_unused;

  assign last_rank = (rank_q == IDX_W'(IMAGE_SIZE - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    gap_load = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (img_valid) state_d = S_START;
        S_START:  state_d = S_SORT;
        S_SORT:   if (sort_done) state_d = S_EMIT;
        S_EMIT: begin
          if (spike_ready) begin
            if (last_rank) begin
              state_d = S_FINISH;
            end else if (SPIKE_GAP > 0) begin
              state_d  = S_GAP;
              gap_load = 1'b1;
            end
          end
        end
        S_GAP:    if (gap_zero) state_d = S_EMIT;
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: the frame and index buffers are small flop arrays, not RAM, so they
  // are cleared on reset and the sorter never sees stale pixels.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      rank_q  <= '0;
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        sidx_q[i]  <= '0;
        image_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (!abort) begin
        if (state_q == S_IDLE && img_valid)
          image_q <= image;
        if (state_q == S_SORT && sort_done) begin
          for (int i = 0; i < IMAGE_SIZE; i++)
            sidx_q[i] <= IDX_W'(sorted_indexes[i]);
          rank_q <= '0;
        end
        if (state_q == S_EMIT && spike_ready && !last_rank)
          rank_q <= rank_q + IDX_W'(1);
      end
    end
  end

  // Upper bits of each sorter index never exceed the pixel count.
  always_comb begin
    for (int i = 0; i < IMAGE_SIZE; i++)
      sidx_unused[i] = ^sorted_indexes[i];
  end

  spike_gap_timer #(.W(GAP_W)) u_gap_timer (
    .CLK        (CLK),
    .RST        (RST),
    .load       (gap_load),
    .load_value (GAP_LOAD),
    .zero       (gap_zero)
  );

  assign img_ready   = (state_q == S_IDLE);
  assign sort_start  = (state_q == S_START);
  assign spike_valid = (state_q == S_EMIT);
  assign spike_addr  = sidx_q[rank_q[SEL_W-1:0]];
  assign spike_last  = spike_valid && last_rank;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_FINISH);
  assign sort_image  = image_q;

`ifdef SPIKE_TIMESTAMP_EN
  logic [TS_BITS-1:0] ts_q;

  // Cycles elapsed since the first spike of the frame was offered.
  always_ff @(posedge CLK) begin
    if (RST)
      ts_q <= '0;
    else if (state_q == S_SORT && state_d == S_EMIT)
      ts_q <= '0;
    else if (ts_q != '1)
      ts_q <= ts_q + TS_BITS'(1);
  end

  assign spike_time = spike_valid ? ts_q : '0;
`else
  localparam int ts_bits_unused = TS_BITS;
`endif

endmodule

// File: tb/tb_rank_spike_scheduler.sv
// Directed self-checking bench for rank_spike_scheduler with a behavioural
// sorter2 stand-in (descending value, ties by lower index).
module tb_rank_spike_scheduler;

  localparam int N   = 5;
  localparam int PB  = 4;
  localparam int PW  = PB + 1;
  localparam int AB  = 3;
  localparam int TSB = 16;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // DUT with SPIKE_GAP = 0
  logic          img_valid, abort, sort_done, spike_ready;
  logic          img_ready, sort_start, spike_valid, spike_last, busy, frame_done;
  logic [PB:0]   image [0:N-1];
  logic [PB:0]   sort_image [0:N-1];
  logic [PB:0]   sorted_indexes [0:N-1];
  logic [AB:0]   spike_addr;
  // DUT with SPIKE_GAP = 2
  logic          img_valid_g, abort_g, sort_done_g, spike_ready_g;
  logic          img_ready_g, sort_start_g, spike_valid_g, spike_last_g, busy_g, frame_done_g;
  logic [PB:0]   image_g [0:N-1];
  logic [PB:0]   sort_image_g [0:N-1];
  logic [PB:0]   sorted_indexes_g [0:N-1];
  logic [AB:0]   spike_addr_g;
`ifdef SPIKE_TIMESTAMP_EN
  logic [TSB-1:0] spike_time, spike_time_g;
`endif

  logic [PB:0] img_a [0:N-1];
  logic [PB:0] img_b [0:N-1];
  logic [AB:0] exp_a [0:N-1];
  logic [AB:0] exp_b [0:N-1];

  rank_spike_scheduler #(.SPIKE_GAP(0)) dut (
    .CLK(CLK), .RST(RST), .img_valid(img_valid), .img_ready(img_ready), .image(image),
    .abort(abort), .sort_image(sort_image), .sort_start(sort_start), .sort_done(sort_done),
    .sorted_indexes(sorted_indexes), .spike_valid(spike_valid), .spike_ready(spike_ready),
    .spike_addr(spike_addr), .spike_last(spike_last), .busy(busy), .frame_done(frame_done)
`ifdef SPIKE_TIMESTAMP_EN
    , .spike_time(spike_time)
`endif
  );

  rank_spike_scheduler #(.SPIKE_GAP(2)) dut_gap (
    .CLK(CLK), .RST(RST), .img_valid(img_valid_g), .img_ready(img_ready_g), .image(image_g),
    .abort(abort_g), .sort_image(sort_image_g), .sort_start(sort_start_g), .sort_done(sort_done_g),
    .sorted_indexes(sorted_indexes_g), .spike_valid(spike_valid_g), .spike_ready(spike_ready_g),
    .spike_addr(spike_addr_g), .spike_last(spike_last_g), .busy(busy_g), .frame_done(frame_done_g)
`ifdef SPIKE_TIMESTAMP_EN
    , .spike_time(spike_time_g)
`endif
  );

  // Sorter stand-in: indexes follow sort_image, done pulses 4 cycles after start.
  always_comb begin
    int pos;
    for (int i = 0; i < N; i++) sorted_indexes[i] = '0;
    for (int i = 0; i < N; i++) begin
      pos = 0;
      for (int j = 0; j < N; j++)
        if (sort_image[j] > sort_image[i] || (sort_image[j] == sort_image[i] && j < i)) pos++;
      sorted_indexes[pos] = PW'(i);
    end
  end

  always_comb begin
    int pos;
    for (int i = 0; i < N; i++) sorted_indexes_g[i] = '0;
    for (int i = 0; i < N; i++) begin
      pos = 0;
      for (int j = 0; j < N; j++)
        if (sort_image_g[j] > sort_image_g[i] || (sort_image_g[j] == sort_image_g[i] && j < i)) pos++;
      sorted_indexes_g[pos] = PW'(i);
    end
  end

  logic [2:0] srt_cnt, srt_cnt_g;
  always @(posedge CLK) begin
    if (RST) begin
      srt_cnt <= '0; sort_done <= 1'b0;
    end else begin
      sort_done <= 1'b0;
      if (sort_start) srt_cnt <= 3'd3;
      else if (srt_cnt != 0) begin
        srt_cnt <= srt_cnt - 3'd1;
        if (srt_cnt == 3'd1) sort_done <= 1'b1;
      end
    end
  end

  always @(posedge CLK) begin
    if (RST) begin
      srt_cnt_g <= '0; sort_done_g <= 1'b0;
    end else begin
      sort_done_g <= 1'b0;
      if (sort_start_g) srt_cnt_g <= 3'd3;
      else if (srt_cnt_g != 0) begin
        srt_cnt_g <= srt_cnt_g - 3'd1;
        if (srt_cnt_g == 3'd1) sort_done_g <= 1'b1;
      end
    end
  end

  function automatic logic [N*PW-1:0] pack(input logic [PB:0] a [0:N-1]);
    logic [N*PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*PW +: PW] = a[i];
    return r;
  endfunction

  task automatic send_frame(input string tag);
    int n;
    n = 0;
    while (img_ready !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    if (img_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s img_ready timeout got=%b want=1", tag, img_ready);
    end
    img_valid = 1'b1;
    @(negedge CLK);
    img_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (spike_valid !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    if (spike_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s spike_valid timeout got=%b want=1", tag, spike_valid);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [AB:0] exp [0:N-1]);
    wait_valid(tag);
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({spike_valid, spike_last, spike_addr} !== {1'b1, (k == N-1), exp[k]}) begin
        failures++;
        $display("FAIL %s spike%0d valid/last/addr got=%b/%b/%0d want=1/%b/%0d",
                 tag, k, spike_valid, spike_last, spike_addr, (k == N-1), exp[k]);
      end
      @(negedge CLK);
    end
    checks++;
    if ({frame_done, spike_valid} !== 2'b10) begin
      failures++;
      $display("FAIL %s finish frame_done/valid got=%b/%b want=1/0", tag, frame_done, spike_valid);
    end
    @(negedge CLK);
    checks++;
    if ({frame_done, img_ready} !== 2'b01) begin
      failures++;
      $display("FAIL %s idle frame_done/img_ready got=%b/%b want=0/1", tag, frame_done, img_ready);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({img_ready, sort_start, spike_valid, spike_last, busy, frame_done, spike_addr} !== {1'b1, 9'b0}) begin
      failures++;
      $display("FAIL reset outputs got=%b%b%b%b%b%b_%0d want=100000_0", img_ready, sort_start,
               spike_valid, spike_last, busy, frame_done, spike_addr);
    end
    checks++;
    if (pack(sort_image) !== '0) begin
      failures++;
      $display("FAIL reset sort_image got=%h want=0", pack(sort_image));
    end
  endtask

  task automatic test_full_frame();
    int n;
    spike_ready = 1'b1;
    image = img_a;
    send_frame("full");
    checks++;
    if ({sort_start, busy, img_ready} !== 3'b110) begin
      failures++;
      $display("FAIL full start start/busy/ready got=%b%b%b want=110", sort_start, busy, img_ready);
    end
    checks++;
    if (pack(sort_image) !== pack(img_a)) begin
      failures++;
      $display("FAIL full capture got=%h want=%h", pack(sort_image), pack(img_a));
    end
    @(negedge CLK);
    checks++;
    if ({sort_start, busy} !== 2'b01) begin
      failures++;
      $display("FAIL full sort start/busy got=%b%b want=01", sort_start, busy);
    end
    n = 0;
    while (sort_done !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    @(negedge CLK);
    checks++;
    if (spike_valid !== 1'b1) begin
      failures++;
      $display("FAIL full latency spike_valid got=%b want=1", spike_valid);
    end
    expect_frame("full", exp_a);
  endtask

  task automatic test_backpressure();
    logic pat [0:3];
    logic stalled;
    logic [AB:0] held;
    int vc, n, cyc;
    bit fd;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    stalled = 1'b0; held = '0; vc = 0; n = 0; cyc = 0; fd = 1'b0;
    spike_ready = 1'b1;
    image = img_a;
    send_frame("bp");
    while (!fd && cyc < 80) begin
      if (frame_done === 1'b1) fd = 1'b1;
      else begin
        if (spike_valid === 1'b1) begin
          if (stalled) begin
            checks++;
            if (spike_addr !== held) begin
              failures++;
              $display("FAIL bp hold addr got=%0d want=%0d", spike_addr, held);
            end
          end
          spike_ready = pat[vc % 4];
          vc++;
          if (spike_ready) begin
            checks++;
            if (n >= N || spike_addr !== exp_a[n % N]) begin
              failures++;
              $display("FAIL bp accept%0d addr got=%0d want=%0d", n, spike_addr, exp_a[n % N]);
            end
            n++;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held = spike_addr;
          end
        end
        cyc++;
        @(negedge CLK);
      end
    end
    spike_ready = 1'b1;
    checks++;
    if (n != N || !fd) begin
      failures++;
      $display("FAIL bp count accepted=%0d done=%b want=%0d/1", n, fd, N);
    end
    @(negedge CLK);
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL bp single frame_done got=%b want=0", frame_done);
    end
  endtask

  task automatic test_spike_gap();
    int n, idle, cyc;
    n = 0; idle = 0; cyc = 0;
    spike_ready_g = 1'b1;
    image_g = img_a;
    img_valid_g = 1'b1;
    @(negedge CLK);
    img_valid_g = 1'b0;
    while (frame_done_g !== 1'b1 && cyc < 80) begin
      if (spike_valid_g === 1'b1) begin
        if (n > 0) begin
          checks++;
          if (idle != 2) begin
            failures++;
            $display("FAIL gap idle before spike%0d got=%0d want=2", n, idle);
          end
        end
        checks++;
        if (n >= N || spike_addr_g !== exp_a[n % N]) begin
          failures++;
          $display("FAIL gap spike%0d addr got=%0d want=%0d", n, spike_addr_g, exp_a[n % N]);
        end
        n++;
        idle = 0;
      end else if (n > 0) idle++;
      cyc++;
      @(negedge CLK);
    end
    checks++;
    if (n != N || frame_done_g !== 1'b1) begin
      failures++;
      $display("FAIL gap total spikes=%0d done=%b want=%0d/1", n, frame_done_g, N);
    end
  endtask

  task automatic test_abort();
    bit stray;
    spike_ready = 1'b1;
    image = img_a;
    send_frame("abort_sort");
    @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    checks++;
    if ({img_ready, busy, frame_done} !== 3'b100) begin
      failures++;
      $display("FAIL abort_sort ready/busy/done got=%b%b%b want=100", img_ready, busy, frame_done);
    end
    stray = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (frame_done !== 1'b0 || spike_valid !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      failures++;
      $display("FAIL abort_sort stray activity got=1 want=0");
    end

    send_frame("abort_emit");
    wait_valid("abort_emit");
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (spike_addr !== exp_a[2]) begin
      failures++;
      $display("FAIL abort_emit rank2 addr got=%0d want=%0d", spike_addr, exp_a[2]);
    end
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    checks++;
    if ({img_ready, spike_valid, busy, frame_done} !== 4'b1000) begin
      failures++;
      $display("FAIL abort_emit ready/valid/busy/done got=%b%b%b%b want=1000",
               img_ready, spike_valid, busy, frame_done);
    end
    stray = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (frame_done !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      failures++;
      $display("FAIL abort_emit frame_done got=1 want=0");
    end

    image = img_b;
    send_frame("abort_next");
    expect_frame("abort_next", exp_b);
  endtask

  task automatic test_busy_reset();
    bit stray;
    spike_ready = 1'b1;
    image = img_a;
    send_frame("busy");
    wait_valid("busy");
    image = img_b;
    img_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (k == 3) img_valid = 1'b0;
      checks++;
      if ({img_ready, spike_valid, spike_addr} !== {1'b0, 1'b1, exp_a[k]}) begin
        failures++;
        $display("FAIL busy spike%0d ready/valid/addr got=%b/%b/%0d want=0/1/%0d",
                 k, img_ready, spike_valid, spike_addr, exp_a[k]);
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (pack(sort_image) !== pack(img_a) || busy !== 1'b0 || sort_start !== 1'b0) begin
      failures++;
      $display("FAIL busy ignored image got=%h busy=%b start=%b want=%h/0/0",
               pack(sort_image), busy, sort_start, pack(img_a));
    end

    image = img_a;
    send_frame("rst");
    wait_valid("rst");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if ({img_ready, sort_start, spike_valid, spike_last, busy, frame_done, spike_addr} !== {1'b1, 9'b0}) begin
      failures++;
      $display("FAIL rst outputs got=%b%b%b%b%b%b_%0d want=100000_0", img_ready, sort_start,
               spike_valid, spike_last, busy, frame_done, spike_addr);
    end
    checks++;
    if (pack(sort_image) !== '0) begin
      failures++;
      $display("FAIL rst sort_image got=%h want=0", pack(sort_image));
    end
    stray = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (sort_start !== 1'b0 || frame_done !== 1'b0 || spike_valid !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      failures++;
      $display("FAIL rst stray start/done/valid got=1 want=0");
    end
  endtask

`ifdef SPIKE_TIMESTAMP_EN
  task automatic test_timestamp();
    int n;
    spike_ready = 1'b0;
    image = img_a;
    send_frame("ts");
    wait_valid("ts");
    repeat (3) @(negedge CLK);
    checks++;
    if ({spike_time, spike_addr} !== {16'd3, exp_a[0]}) begin
      failures++;
      $display("FAIL ts spike0 time/addr got=%0d/%0d want=3/%0d", spike_time, spike_addr, exp_a[0]);
    end
    spike_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if ({spike_time, spike_addr} !== {16'd4, exp_a[1]}) begin
      failures++;
      $display("FAIL ts spike1 time/addr got=%0d/%0d want=4/%0d", spike_time, spike_addr, exp_a[1]);
    end
    n = 0;
    while (frame_done !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    @(negedge CLK);
  endtask
`endif

  initial begin
    img_a = '{5'd3, 5'd10, 5'd7, 5'd10, 5'd0};
    img_b = '{5'd0, 5'd5, 5'd9, 5'd2, 5'd9};
    exp_a = '{4'd1, 4'd3, 4'd2, 4'd0, 4'd4};
    exp_b = '{4'd2, 4'd4, 4'd1, 4'd3, 4'd0};
    img_valid = 1'b0; abort = 1'b0; spike_ready = 1'b0;
    img_valid_g = 1'b0; abort_g = 1'b0; spike_ready_g = 1'b0;
    image = img_a; image_g = img_a;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_spike_gap();
    test_abort();
    test_busy_reset();
`ifdef SPIKE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rank_spike_scheduler.md
# rank_spike_scheduler

- Sequences one `sorter2` rank-order encoder per frame: captures an input image, holds it stable while the sorter runs, and snapshots the sorted pixel indexes.
- Streams the snapshot to the SNN core as address-event spikes under a valid/ready handshake, brightest pixel first.
- Sits between the image source and the neuron core; it is the only driver of the sorter's `image` and `new_image` inputs.

## Interface
Parameters:
- `IMAGE_SIZE`, 5: pixels per frame.
- `IMAGE_SIZE_BITS`, `$clog2(IMAGE_SIZE)`: index width minus one.
- `PIXEL_MAX_VALUE`, 10: maximum pixel intensity.
- `PIXEL_BITS`, `$clog2(PIXEL_MAX_VALUE)`: pixel width minus one.
- `SPIKE_GAP`, 0: idle cycles inserted after each accepted spike.
- `TS_BITS`, 16: timestamp width (used only with `SPIKE_TIMESTAMP_EN`).

Ports:
- `CLK` in, 1: the single clock.
- `RST` in, 1: reset, synchronous and active-high.
- `img_valid` in, 1: `image` holds a new frame.
- `img_ready` out, 1: block can accept a frame.
- `image` in, `[PIXEL_BITS:0] [0:IMAGE_SIZE-1]`: input frame.
- `abort` in, 1: drop the current frame and return to IDLE.
- `sort_image` out, `[PIXEL_BITS:0] [0:IMAGE_SIZE-1]`: captured frame, drives the sorter's `image`.
- `sort_start` out, 1: one-cycle pulse, drives the sorter's `new_image`.
- `sort_done` in, 1: from the sorter's `done`.
- `sorted_indexes` in, `[PIXEL_BITS:0] [0:IMAGE_SIZE-1]`: from the sorter.
- `spike_valid` out, 1: a spike event is presented.
- `spike_ready` in, 1: the core accepts the spike.
- `spike_addr` out, `[IMAGE_SIZE_BITS:0]`: pixel index of the spike.
- `spike_last` out, 1: final spike of the frame.
- `busy` out, 1: the block is not in IDLE.
- `frame_done` out, 1: one-cycle pulse after the last spike is accepted.

## Operation
States: IDLE, START, SORT, EMIT, GAP, FINISH.

- **IDLE:** `img_ready`=1. On `img_valid`:
  - latch `image` into `sort_image`;
  - go to START.
- **START:** `sort_start`=1 for exactly one cycle, then go to SORT.
- **SORT:** wait for `sort_done`. When it is seen:
  - copy `sorted_indexes` into the local buffer `sidx_q`, keeping the low `IMAGE_SIZE_BITS+1` bits of each entry;
  - set `rank` to 0;
  - go to EMIT.
- **EMIT:** `spike_valid`=1, `spike_addr`=`sidx_q[rank]`, `spike_last`=(`rank`==`IMAGE_SIZE-1`). On `spike_valid && spike_ready`:
  - if this is the last spike, go to FINISH;
  - otherwise increment `rank`, then go to GAP if `SPIKE_GAP`>0, else stay in EMIT.
- **GAP:** `spike_valid`=0 while `gap_cnt` counts `SPIKE_GAP` cycles, then go to EMIT.
- **FINISH:** `frame_done`=1 for one cycle, then go to IDLE.

Rules:
- `sort_image` stays constant from capture until the block re-enters IDLE, because the sorter reads it combinationally.
- `abort` has priority over every other event. From any state it forces IDLE on the next edge with no `frame_done`. `sort_image` and `sidx_q` are kept.
- `img_valid` outside IDLE is ignored (`img_ready`=0).
- `sort_done` outside SORT is ignored.
- `busy` = (state != IDLE).
- `rank` is `IMAGE_SIZE_BITS+1` bits wide and never exceeds `IMAGE_SIZE-1`.
- `gap_cnt` is `$clog2(SPIKE_GAP+1)` bits wide, with a minimum of 1.

## Timing
- **Reset:** while `RST` is high at an edge, state goes to IDLE and `rank`, `gap_cnt`, `sidx_q` and `sort_image` are cleared. In the cycle after reset, all outputs are 0 except `img_ready`=1. `RST` mid-frame abandons the frame silently.
- **Handshakes:** a transfer occurs on a rising edge where valid and ready are both 1. While `spike_valid`=1 and `spike_ready`=0, `spike_addr` and `spike_last` are held stable.
- **Latency:**
  - image accepted at edge 0;
  - `sort_start` high in cycle 1;
  - `sort_done` sampled high at edge N gives `spike_valid` in cycle N+1.
- **Frame throughput:** with `spike_ready` tied high and `SPIKE_GAP`=0, one spike per cycle for `IMAGE_SIZE` cycles, then one FINISH cycle. The next image can be accepted 2 cycles after the last spike.
- All outputs are decoded from registered state/data only; there is no input-to-output combinational path.

## Configuration
- `SPIKE_TIMESTAMP_EN` defined:
  - adds output `spike_time [TS_BITS-1:0]`;
  - the counter clears on entry to EMIT from SORT and increments every cycle, saturating at all-ones;
  - `spike_time` is valid with `spike_valid`.
- Undefined: the port and its counter are absent; the behaviour is otherwise identical.

## Structure
- Shared package `snn_encoder_pkg`:
  - `sched_state_t` enum;
  - default `IMAGE_SIZE` / `PIXEL_MAX_VALUE` constants, shared with `sorter2`.
- The sorter stays external. A wrapper `rank_encoder_top` instantiates `sorter2` plus this block.
- Sub-module `spike_gap_timer`: loadable down-counter with a `zero` flag, used in GAP.

## Test plan
1. **Full frame:** `image`={3,10,7,10,0} with a real `sorter2` and `spike_ready`=1 -> `spike_addr` 1,3,2,0,4 on consecutive cycles, `spike_last` on addr 4, one `frame_done` pulse.
2. **Backpressure:** toggle `spike_ready` 1,0,0,1 -> `spike_addr` held during stalls, no spike dropped or duplicated, same order as test 1.
3. **Spike gap:** `SPIKE_GAP`=2 -> exactly 2 idle cycles between consecutive `spike_valid` cycles, 5 spikes total.
4. **Abort:** assert `abort` during SORT, then during EMIT at rank 2 -> IDLE next cycle, `img_ready`=1, no `frame_done`; a following frame encodes correctly.
5. **Busy/reset behaviour:** assert `img_valid` during EMIT, and `RST` mid-frame -> the image is ignored while busy; after reset the outputs are zero, `img_ready`=1, and there is no stray `sort_start`.
6. **Timestamp:** `SPIKE_TIMESTAMP_EN` defined with `spike_ready` stalled for 3 cycles on spike 0 -> `spike_time` = 3 when spike 0 is accepted, 4 on spike 1.
